// File: rtl/xor_stream_cipher.sv
// XOR stream-cipher core: Galois LFSR keystream, one-stage registered datapath,
// valid/ready on both sides. Optional self-check enabled by XOR_CIPHER_CHECK_EN.
module xor_stream_cipher #(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int                WARMUP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              chk_err
);

  typedef enum logic {ST_WARM, ST_RUN} state_t;

  localparam state_t     ST_INIT   = (WARMUP == 0) ? ST_RUN : ST_WARM;
  localparam logic [7:0] WARM_LAST = 8'((WARMUP == 0) ? 0 : WARMUP - 1);

  // One advance = DATA_W Galois steps, so every keystream word is fresh bits.
  function automatic logic [LFSR_W-1:0] f_advance(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] t;
    t = s;
    for (int unsigned i = 0; i < DATA_W; i++)
      t = (t >> 1) ^ (t[0] ? TAPS : '0);
    return t;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [LFSR_W-1:0]   r_lfsr, w_lfsr_nxt;
  logic [7:0]          r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                w_in_ready;
  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_adv;
  logic [LFSR_W-1:0]   w_seed;

  assign w_seed     = (seed_in == '0) ? SEED : seed_in;
  assign w_in_fire  = in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_cnt_nxt   = r_cnt;
    w_in_ready  = 1'b0;
    w_adv       = 1'b0;
    busy        = (r_state == ST_WARM);
    if (seed_load) begin
      w_lfsr_nxt  = w_seed;
      w_cnt_nxt   = '0;
      w_state_nxt = ST_INIT;
    end else begin
      case (r_state)
        ST_WARM: begin
          w_adv     = 1'b1;
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt == WARM_LAST)
            w_state_nxt = ST_RUN;
        end
        default: begin
          w_in_ready = !r_out_valid || out_ready;
          w_adv      = in_valid && w_in_ready;
        end
      endcase
      if (w_adv)
        w_lfsr_nxt = f_advance(r_lfsr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_lfsr      <= SEED;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_in_fire) begin
        r_out_data  <= in_data ^ r_lfsr[DATA_W-1:0];
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifdef XOR_CIPHER_CHECK_EN
  logic [LFSR_W-1:0] r_sh_lfsr;
  logic [DATA_W-1:0] r_chk_in;
  logic [DATA_W-1:0] r_chk_k;
  logic              r_chk_err;

  // Shadow keystream word is captured at accept so the check survives the advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_lfsr <= SEED;
      r_chk_in  <= '0;
      r_chk_k   <= '0;
      r_chk_err <= 1'b0;
    end else begin
      if (seed_load)
        r_sh_lfsr <= w_seed;
      else if (w_adv)
        r_sh_lfsr <= f_advance(r_sh_lfsr);
      if (w_in_fire) begin
        r_chk_in <= in_data;
        r_chk_k  <= r_sh_lfsr[DATA_W-1:0];
      end
      if (w_out_fire && ((r_out_data ^ r_chk_k) != r_chk_in))
        r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

endmodule
